// File: rtl/fft_band_reader_pkg.sv
// Shared types and constants for the FFT band-power reader.
// Holds the FSM encoding, FIFO word layout and default parameter values.
package fft_band_reader_pkg;

  localparam int unsigned POINTS_DEF     = 512;
  localparam int unsigned NBANDS_DEF     = 8;
  localparam int unsigned ACC_W_DEF      = 40;
  localparam int unsigned RD_LATENCY_DEF = 1;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned RE_LSB = 0;
  localparam int unsigned IM_LSB = 16;
  localparam int unsigned POW_W  = 33;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_MAC  = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [HALF_W-1:0] im;
    logic signed [HALF_W-1:0] re;
  } fft_word_t;

  // Index width that stays legal for a count of one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_band_reader_if.sv
// FIFO read port plus host-side band result / interrupt signals.
interface fft_band_reader_if
  import fft_band_reader_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned ACC_W = ACC_W_DEF
) ();

  logic              enable;
  logic              fft_rdy;
  logic [WORD_W-1:0] fft_out;
  logic              rd_strobe;
  logic [SEL_W-1:0]  band_sel;
  logic [ACC_W-1:0]  band_pow;
  logic              irq_clr;
  logic              irq;
  logic              ovf;
  logic [7:0]        frame_cnt;

  modport master (
    input  enable, fft_rdy, fft_out, band_sel, irq_clr,
    output rd_strobe, band_pow, irq, ovf, frame_cnt
  );

  modport slave (
    output enable, fft_rdy, fft_out, band_sel, irq_clr,
    input  rd_strobe, band_pow, irq, ovf, frame_cnt
  );

endinterface

// File: rtl/fft_pow_mac.sv
// Combinational bin power (re^2 + im^2, full 33 bits) and saturating
// accumulate into an ACC_W-bit band accumulator.
module fft_pow_mac
  import fft_band_reader_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [WORD_W-1:0] word,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [ACC_W-1:0]  acc_sum_c
);

  localparam int unsigned SUM_W = ((ACC_W > POW_W) ? ACC_W : POW_W) + 1;

  logic signed [HALF_W-1:0]   re;
  logic signed [HALF_W-1:0]   im;
  logic signed [2*HALF_W-1:0] re_sq;
  logic signed [2*HALF_W-1:0] im_sq;
  logic [POW_W-1:0]           pow;
  logic [SUM_W-1:0]           sum;
  logic [SUM_W-1:0]           acc_max;

  always_comb begin
    re      = word[RE_LSB +: HALF_W];
    im      = word[IM_LSB +: HALF_W];
    re_sq   = (2*HALF_W)'(re) * (2*HALF_W)'(re);
    im_sq   = (2*HALF_W)'(im) * (2*HALF_W)'(im);
    pow     = POW_W'($unsigned(re_sq)) + POW_W'($unsigned(im_sq));
    sum     = SUM_W'(acc_in) + SUM_W'(pow);
    acc_max = SUM_W'({ACC_W{1'b1}});
    acc_sum_c = (sum > acc_max) ? {ACC_W{1'b1}} : ACC_W'(sum);
  end

endmodule

// File: rtl/fft_band_reader.sv
// Reads FFT result words from a FIFO, accumulates per-band power over the
// lower half of each frame and latches band results with an interrupt.
module fft_band_reader
  import fft_band_reader_pkg::*;
#(
  parameter int unsigned POINTS     = POINTS_DEF,
  parameter int unsigned NBANDS     = NBANDS_DEF,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  fft_band_reader_if.master bus
);

  localparam int unsigned HALF_PTS     = POINTS / 2;
  localparam int unsigned BIN_PER_BAND = HALF_PTS / NBANDS;
  localparam int unsigned BIN_W        = idx_width(POINTS);
  localparam int unsigned SEL_W        = idx_width(NBANDS);
  localparam int unsigned LAT_W        = idx_width(RD_LATENCY);

  state_e            state_q, state_d;
  logic              rd_strobe_q, rd_strobe_d;
  logic              abort_q, abort_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              irq_q, irq_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [ACC_W-1:0]  acc_q [NBANDS];
  logic [ACC_W-1:0]  acc_d [NBANDS];
  logic [ACC_W-1:0]  res_q [NBANDS];
  logic [ACC_W-1:0]  res_d [NBANDS];

  logic [SEL_W-1:0]  band_idx;
  logic              in_low_half;
  logic              last_bin;
  logic [ACC_W-1:0]  mac_sum_c;

  always_comb begin
    band_idx    = SEL_W'(bin_q / BIN_W'(BIN_PER_BAND));
    in_low_half = (bin_q < BIN_W'(HALF_PTS));
    last_bin    = (bin_q == BIN_W'(POINTS - 1));
  end

  fft_pow_mac #(.ACC_W(ACC_W)) u_mac (
    .word      (word_q),
    .acc_in    (acc_q[band_idx]),
    .acc_sum_c (mac_sum_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    lat_d       = lat_q;
    word_d      = word_q;
    bin_d       = bin_q;
    irq_d       = irq_q;
    ovf_d       = ovf_q;
    frame_cnt_d = frame_cnt_q;
    acc_d       = acc_q;
    res_d       = res_q;

    if (bus.irq_clr) irq_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (!bus.enable) begin
          bin_d = '0;
          for (int i = 0; i < NBANDS; i++) acc_d[i] = '0;
        end else if (bus.fft_rdy) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        lat_d   = '0;
        state_d = S_WAIT;
        if (!bus.enable) abort_d = 1'b1;
      end
      S_WAIT: begin
        if (!bus.enable) abort_d = 1'b1;
        if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
          word_d  = bus.fft_out;
          state_d = S_MAC;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_MAC: begin
        // Any enable drop since the read was issued throws the frame away.
        if (abort_q || !bus.enable) begin
          abort_d = 1'b0;
          bin_d   = '0;
          for (int i = 0; i < NBANDS; i++) acc_d[i] = '0;
        end else begin
          if (in_low_half) acc_d[band_idx] = mac_sum_c;
          bin_d = last_bin ? '0 : bin_q + BIN_W'(1);
          if (last_bin) begin
            res_d = acc_d;
            for (int i = 0; i < NBANDS; i++) acc_d[i] = '0;
            ovf_d       = ovf_q | irq_q;
            irq_d       = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        state_d = (bus.enable && bus.fft_rdy) ? S_RD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rd_strobe_d = (state_d == S_RD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_strobe_q <= 1'b0;
      abort_q     <= 1'b0;
      lat_q       <= '0;
      word_q      <= '0;
      bin_q       <= '0;
      irq_q       <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < NBANDS; i++) begin
        acc_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rd_strobe_q <= rd_strobe_d;
      abort_q     <= abort_d;
      lat_q       <= lat_d;
      word_q      <= word_d;
      bin_q       <= bin_d;
      irq_q       <= irq_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
    end
  end

  assign bus.rd_strobe = rd_strobe_q;
  assign bus.irq       = irq_q;
  assign bus.ovf       = ovf_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.band_pow  = res_q[bus.band_sel];

endmodule

// File: doc/fft_band_reader.md
FFT_BAND_READER -- requirements
Module: fft_band_reader

Interface
REQ-001 Parameter POINTS, default 512: FFT result words per frame.
REQ-002 Parameter NBANDS, default 8: number of power bands; a power of two that divides POINTS/2.
REQ-003 Parameter RD_LATENCY, default 1: cycles from the rd_strobe cycle to valid fft_out.
REQ-004 Parameter ACC_W, default 40: band accumulator width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 enable  in  1  run; a rising edge starts frame alignment at bin 0.
REQ-008 fft_rdy  in  1  result FIFO non-empty.
REQ-009 fft_out  in  32  FIFO word {im[15:0], re[15:0]}, signed two's complement.
REQ-010 rd_strobe  out  1  FIFO read enable, one-cycle pulse.
REQ-011 band_sel  in  log2(NBANDS)  result register select.
REQ-012 band_pow  out  ACC_W  latched power of the selected band, combinational mux of result registers.
REQ-013 irq_clr  in  1  clears irq.
REQ-014 irq  out  1  level; set when a frame result is latched.
REQ-015 ovf  out  1  sticky; a result was overwritten while irq was still set.
REQ-016 frame_cnt  out  8  completed frames, wraps 255->0.

Function
REQ-017 FSM states: IDLE, RD, WAIT, MAC.
- IDLE->RD when enable=1 and fft_rdy=1.
- RD drives rd_strobe=1 for exactly one cycle, then goes to WAIT.
- WAIT lasts RD_LATENCY cycles; fft_out is captured on its last cycle; then MAC.
- MAC->RD if enable=1 and fft_rdy=1, otherwise MAC->IDLE.
REQ-018 At most one read is outstanding; rd_strobe is never asserted outside RD.
REQ-019 MAC computes p = re*re + im*im as an unsigned 33-bit value with no truncation (maximum 2^31 for re=im=-32768).
REQ-020 For bin index b < POINTS/2, p is added to accumulator b/(POINTS/2/NBANDS); the add saturates at 2^ACC_W-1.
REQ-021 Bins b >= POINTS/2 are read and discarded (mirror half).
REQ-022 The bin counter increments in MAC and wraps POINTS-1 -> 0.
REQ-023 On the MAC cycle of bin POINTS-1:
- all accumulator values, including bin POINTS-1's contribution, are copied to the result registers;
- the accumulators are cleared;
- irq is set and frame_cnt increments.
REQ-024 If irq=1 when a new result is latched, ovf is set; ovf clears only on reset.
REQ-025 irq_clr and a latch in the same cycle: set wins.
REQ-026 enable falling mid-frame: an in-flight read completes and its data is discarded; bin counter and accumulators clear; result registers and irq are unchanged.
REQ-027 fft_rdy=0 mid-frame: remain in IDLE with counters held; resume on fft_rdy=1.

Reset
REQ-028 On rst, all of the following clear to 0, taking effect immediately and asynchronously; any in-flight read is abandoned:
- state = IDLE;
- rd_strobe, irq, ovf, frame_cnt;
- bin counter, accumulators, result registers.

Structure
REQ-029 A shared package holds:
- FSM state encoding;
- the 32-bit word split constants (RE_LSB=0, IM_LSB=16);
- defaults for POINTS, NBANDS, ACC_W.
REQ-030 One sub-module, fft_pow_mac, implements the 33-bit power computation and the saturating ACC_W add; it is combinational and is registered in the parent.

Verification
REQ-031 POINTS=16, NBANDS=2, fft_rdy held 1, every word {im=0, re=1}:
- band_pow[0] = band_pow[1] = 4;
- irq rises on the 16th MAC cycle;
- frame_cnt = 1.
REQ-032 RD_LATENCY=2, fft_rdy toggling every 3 cycles:
- rd_strobe never re-asserts before capture;
- no word is dropped or duplicated (scoreboard by ramp data).
REQ-033 Every word {im=16'h8000, re=16'h8000}, ACC_W=33: band_pow saturates at 2^33-1.
REQ-034 Two frames completed without irq_clr:
- ovf=1 and frame_cnt=2;
- with irq_clr asserted on the second frame's latch cycle, irq stays 1.
REQ-035 enable dropped at bin 5 and re-raised:
- next band values reflect only the new frame;
- the earlier result registers are unchanged until the new frame latches.
REQ-036 rst asserted in WAIT: rd_strobe=0 and irq=0 immediately (asynchronously); the following frame aligns at bin 0.
